insn_seq: RTL and testbench
===========================

INSN_SEQ -- requirements
Module: insn_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath and register width.
REQ-002 SHALL have parameter RESET_PC, default 0, first fetch address; it SHALL be a multiple of 4.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port imem_req, output, 1, instruction fetch request.
REQ-006 SHALL have port imem_addr, output, XLEN, fetch address, equal to pc.
REQ-007 SHALL have port imem_ack, input, 1, fetch data valid this cycle.
REQ-008 SHALL have port imem_data, input, 32, fetched instruction word.
REQ-009 SHALL have ports opcode (7), funct3 (3), funct7 (7), imm (20), all outputs, decoded fields driven to the execution unit.
REQ-010 SHALL have ports rs1, rs2, outputs, XLEN, operand values driven to the execution unit.
REQ-011 SHALL have ports rd_enable_write (input, 1) and rd (input, XLEN), result returned by the execution unit.
REQ-012 SHALL have port pc, output, XLEN, address of the current instruction.
REQ-013 SHALL have port halted, output, 1, high once an illegal opcode is decoded.
REQ-014 SHALL have port instret, output, 64, retired-instruction count.

Function
REQ-015 SHALL run a state machine with states FETCH, DECODE, EXEC, WB, HALT.
REQ-016 In FETCH: imem_req=1 and imem_addr=pc, both held stable until imem_ack=1; on ack, latch imem_data into the instruction register and go to DECODE.
REQ-017 imem_ack SHALL be accepted in the same cycle imem_req first rises; imem_ack in any state other than FETCH SHALL be ignored.
REQ-018 In DECODE: opcode=instr[6:0], funct3=instr[14:12], funct7=instr[31:25], imm=instr[31:12]; read registers instr[19:15] and instr[24:20] into the rs1 and rs2 registers.
REQ-019 DECODE SHALL go to EXEC when opcode is 0110111 (LUI) or 0110011 (OP); for any other opcode it SHALL go to HALT.
REQ-020 In EXEC: hold the decoded fields and rs1/rs2 stable; capture rd and rd_enable_write at the end of the cycle; go to WB.
REQ-021 In WB: write the captured rd to register instr[11:7] if the captured enable is 1 and the index is nonzero; set pc=pc+4 modulo 2^XLEN; increment instret; go to FETCH.
REQ-022 Register x0 SHALL always read 0; writes to x0 SHALL be discarded.
REQ-023 HALT SHALL be terminal until reset: halted=1, imem_req=0, no register write, pc frozen at the illegal instruction's address.
REQ-024 Latency SHALL be 4 cycles per instruction with a zero-wait ack (FETCH, DECODE, EXEC, WB), plus one cycle per wait cycle in FETCH.
REQ-025 The register file SHALL be 32 x XLEN, internal, with no read-after-write hazard, because WB completes before the next DECODE.

Reset
REQ-026 Asserting reset SHALL immediately set: state FETCH, pc=RESET_PC, imem_req=0, halted=0, instret=0, instruction register 0, all decoded-field outputs 0, rs1=rs2=0, and all 32 registers 0.
REQ-027 Reset asserted mid-fetch SHALL abandon the outstanding request; an ack that arrives while reset is high SHALL be ignored.
REQ-028 After reset deasserts, imem_req SHALL rise on the first clock edge, and not during reset.

Configuration
REQ-029 Macro INSN_SEQ_INSTRET_EN: when defined, instret SHALL count retirements as in REQ-021, wrapping at 2^64.
REQ-030 When INSN_SEQ_INSTRET_EN is undefined, instret SHALL be constant 0 and no counter SHALL be synthesized.

Verification
REQ-031 Reset, then a zero-wait memory returning LUI x1,0x12345 (0x123450B7), with rd=0x12345 and enable=1 from the execution unit -> after 4 cycles x1=0x00012345, pc=4, instret=1.
REQ-032 ADD x3,x1,x2 (0x002081B3) with x1=5, x2=7, execution unit returning rd=12 -> rs1=5 and rs2=7 during EXEC, x3=12, pc advanced by 4.
REQ-033 LUI x0,0xFFFFF (0xFFFFF037) with rd=0xFFFFF and enable=1 -> x0 still reads 0, instret increments.
REQ-034 imem_ack withheld for 3 cycles -> imem_req and imem_addr stable throughout, instruction completes in 7 cycles.
REQ-035 Opcode 0000011 (0x00002083) -> halted=1 within 2 cycles of ack, imem_req stays 0, pc unchanged for 20 cycles.
REQ-036 Reset pulsed during a FETCH wait and during EXEC -> pc=RESET_PC, halted=0, registers 0, no write occurs.

Source files
------------

// File: rtl/insn_seq.sv
// -----------------------------------------------------------------------------
// insn_seq -- multi-cycle instruction sequencer for a minimal RV32-style core.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> WB and then returns to
// FETCH. Only LUI (0110111) and OP (0110011) are legal. Any other opcode parks
// the sequencer in HALT until the next reset.
//
// The register file (32 x XLEN) is internal. Its operands are read in DECODE
// and presented on rs1/rs2 throughout EXEC. The external execution unit hands
// back rd/rd_enable_write, which are captured at the end of EXEC and written
// in WB. WB always completes before the next DECODE, so there is no
// read-after-write hazard.
//
// Parameters
//   XLEN      datapath and register width (default 32)
//   RESET_PC  first fetch address; must be a multiple of 4
//
// Ports
//   clk             sole clock, rising edge
//   reset           asynchronous, active-high
//   imem_req        fetch request (registered; low during and right after reset)
//   imem_addr       fetch address, always equal to pc
//   imem_ack        fetch data valid; only honoured in FETCH while imem_req is high
//   imem_data       fetched instruction word
//   opcode/funct3/funct7/imm  decoded fields, registered at the end of DECODE
//   rs1, rs2        operand values, registered at the end of DECODE
//   rd_enable_write result write enable from the execution unit
//   rd              result value from the execution unit
//   pc              address of the current instruction
//   halted          high while parked in HALT
//   instret         retired-instruction count
//
// Configuration
//   INSN_SEQ_INSTRET_EN  when defined, instret is a 64-bit wrapping retirement
//                        counter. When undefined, instret is tied to 0 and no
//                        counter is built.
// -----------------------------------------------------------------------------
module insn_seq #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_data,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [19:0]     imm,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  input  logic            rd_enable_write,
  input  logic [XLEN-1:0] rd,
  output logic [XLEN-1:0] pc,
  output logic            halted,
  output logic [63:0]     instret
);

  localparam logic [6:0]      OPC_LUI = 7'b0110111;
  localparam logic [6:0]      OPC_OP  = 7'b0110011;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    HALT   = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic            req_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rd_q;
  logic            rd_we_q;
  logic [XLEN-1:0] regs [32];

  logic            fetch_fire;
  logic            opc_legal;
  logic [4:0]      rs1_idx;
  logic [4:0]      rs2_idx;
  logic [4:0]      rd_idx;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            rf_we;

  // An ack counts only while the request is actually on the bus. This covers
  // the first cycle after reset, where the state is FETCH but imem_req is
  // still low.
  assign fetch_fire = (state_q == FETCH) && req_q && imem_ack;

  assign opc_legal  = (instr_q[6:0] == OPC_LUI) || (instr_q[6:0] == OPC_OP);

  assign rs1_idx    = instr_q[19:15];
  assign rs2_idx    = instr_q[24:20];
  assign rd_idx     = instr_q[11:7];

  // x0 is forced to zero on read. It is also never written, so the array
  // entry itself stays zero after reset.
  assign rs1_val    = (rs1_idx == 5'd0) ? '0 : regs[rs1_idx];
  assign rs2_val    = (rs2_idx == 5'd0) ? '0 : regs[rs2_idx];

  assign rf_we      = (state_q == WB) && rd_we_q && (rd_idx != 5'd0);

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign halted     = (state_q == HALT);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (fetch_fire) state_d = DECODE;
      DECODE:  state_d = opc_legal ? EXEC : HALT;
      EXEC:    state_d = WB;
      WB:      state_d = FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register and fetch request
  // ---------------------------------------------------------------------------
  // imem_req is registered on "next state is FETCH". It therefore stays low
  // while reset is asserted and rises on the first clock edge after release.
  // It also rises on the WB -> FETCH edge, so a zero-wait ack lands in the
  // first FETCH cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= (state_d == FETCH);
    end
  end

  // ---------------------------------------------------------------------------
  // FETCH boundary: instruction register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr_q <= '0;
    end else if (fetch_fire) begin
      instr_q <= imem_data;
    end
  end

  // ---------------------------------------------------------------------------
  // DECODE boundary: decoded fields and operand values
  // ---------------------------------------------------------------------------
  // These are loaded only on leaving DECODE, so they hold steady through
  // EXEC and WB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opcode <= '0;
      funct3 <= '0;
      funct7 <= '0;
      imm    <= '0;
      rs1    <= '0;
      rs2    <= '0;
    end else if (state_q == DECODE) begin
      opcode <= instr_q[6:0];
      funct3 <= instr_q[14:12];
      funct7 <= instr_q[31:25];
      imm    <= instr_q[31:12];
      rs1    <= rs1_val;
      rs2    <= rs2_val;
    end
  end

  // ---------------------------------------------------------------------------
  // EXEC boundary: capture the execution unit's result
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      rd_we_q <= 1'b0;
    end else if (state_q == EXEC) begin
      rd_q    <= rd;
      rd_we_q <= rd_enable_write;
    end
  end

  // ---------------------------------------------------------------------------
  // WB boundary: register write and pc advance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_we) begin
      regs[rd_idx] <= rd_q;
    end
  end

  // pc only moves in WB. In HALT it stays at the illegal instruction's
  // address. The addition wraps naturally at 2^XLEN.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else if (state_q == WB) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

`ifdef INSN_SEQ_INSTRET_EN
  logic [63:0] instret_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else if (state_q == WB) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_insn_seq.sv
// -----------------------------------------------------------------------------
// tb_insn_seq -- self-checking bench for insn_seq.
//
// A reference register file and pc are kept in the bench. When an
// instruction is issued, its expected decoded fields and operand values are
// pushed to a scoreboard queue. The entry is popped and compared once the
// DUT reaches EXEC.
// -----------------------------------------------------------------------------
module tb_insn_seq;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_data;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [19:0]     imm;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            rd_enable_write;
  logic [XLEN-1:0] rd;
  logic [XLEN-1:0] pc;
  logic            halted;
  logic [63:0]     instret;

  insn_seq #(.XLEN(XLEN), .RESET_PC('0)) dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_data       (imem_data),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .imm             (imm),
    .rs1             (rs1),
    .rs2             (rs2),
    .rd_enable_write (rd_enable_write),
    .rd              (rd),
    .pc              (pc),
    .halted          (halted),
    .instret         (instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [19:0]     imm;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
  } exp_t;

  exp_t            sb_q [$];
  logic [XLEN-1:0] mregs [32];
  logic [XLEN-1:0] mpc;
  logic [63:0]     mret;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    mpc  = '0;
    mret = '0;
    sb_q.delete();
  endtask

  function automatic logic [63:0] exp_instret();
`ifdef INSN_SEQ_INSTRET_EN
    return mret;
`else
    return 64'd0;
`endif
  endfunction

  // Issue one instruction. "waits" is the number of cycles the ack is
  // withheld. The execution unit drives rdv/en during EXEC only and then
  // inverts them, so a late capture is caught. Spurious acks with an illegal
  // word are driven outside FETCH and must be ignored.
  task automatic do_insn(input logic [31:0] word, input logic [XLEN-1:0] rdv,
                         input logic en, input int waits);
    exp_t e;
    exp_t got;
    logic legal;
    int   guard;
    legal = (word[6:0] == 7'b0110111) || (word[6:0] == 7'b0110011);
    e.opcode = word[6:0];
    e.funct3 = word[14:12];
    e.funct7 = word[31:25];
    e.imm    = word[31:12];
    e.rs1    = mregs[word[19:15]];
    e.rs2    = mregs[word[24:20]];
    if (legal) sb_q.push_back(e);

    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (imem_req !== 1'b1) begin
      check_eq("req_timeout", {63'd0, imem_req}, 64'd1);
      return;
    end
    check_eq("fetch_addr", imem_addr, mpc);

    for (int i = 0; i < waits; i++) begin
      step();
      check_eq("wait_req", {63'd0, imem_req}, 64'd1);
      check_eq("wait_addr", imem_addr, mpc);
    end

    imem_ack  = 1'b1;
    imem_data = word;
    step();                              // now in DECODE
    imem_data = 32'h0000_0003;           // illegal word on spurious acks
    check_eq("req_drop", {63'd0, imem_req}, 64'd0);

    if (!legal) begin
      imem_ack = 1'b0;
      step();                            // now in HALT
      check_eq("halted", {63'd0, halted}, 64'd1);
      check_eq("halt_req", {63'd0, imem_req}, 64'd0);
      check_eq("halt_pc", pc, mpc);
      return;
    end

    step();                              // now in EXEC
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      check_eq("opcode", opcode, got.opcode);
      check_eq("funct3", funct3, got.funct3);
      check_eq("funct7", funct7, got.funct7);
      check_eq("imm", imm, got.imm);
      check_eq("rs1", rs1, got.rs1);
      check_eq("rs2", rs2, got.rs2);
    end
    rd              = rdv;
    rd_enable_write = en;
    step();                              // now in WB
    rd              = ~rdv;
    rd_enable_write = ~en;
    check_eq("wb_pc_hold", pc, mpc);
    step();                              // back in FETCH
    imem_ack = 1'b0;
    if (en && word[11:7] != 5'd0) mregs[word[11:7]] = rdv;
    mpc  = mpc + XLEN'(4);
    mret = mret + 64'd1;
    check_eq("retire_pc", pc, mpc);
    check_eq("instret", instret, exp_instret());
    check_eq("refetch_req", {63'd0, imem_req}, 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset           = 1'b0;
    imem_ack        = 1'b0;
    imem_data       = '0;
    rd              = '0;
    rd_enable_write = 1'b0;
    model_reset();
    #2 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pc", pc, 64'd0);
    check_eq("rst_req", {63'd0, imem_req}, 64'd0);
    check_eq("rst_halted", {63'd0, halted}, 64'd0);
    check_eq("rst_instret", instret, 64'd0);
    check_eq("rst_rs1", rs1, 64'd0);
    #2 reset = 1'b0;
    #1 check_eq("req_post_rst", {63'd0, imem_req}, 64'd0);
    step();
    check_eq("req_first_edge", {63'd0, imem_req}, 64'd1);

    do_insn(32'h1234_50B7, 32'h0001_2345, 1'b1, 0);  // LUI x1,0x12345
    do_insn(32'h0020_81B3, 32'h0000_0005, 1'b0, 0);  // ADD x3,x1,x2, no write
    do_insn(32'h0000_00B7, 32'h0000_0005, 1'b1, 0);  // x1 = 5
    do_insn(32'h0000_0137, 32'h0000_0007, 1'b1, 1);  // x2 = 7
    do_insn(32'h0020_81B3, 32'h0000_000C, 1'b1, 0);  // ADD x3,x1,x2 = 12
    do_insn(32'hFFFF_F037, 32'h000F_FFFF, 1'b1, 0);  // LUI x0 discarded
    do_insn(32'h0030_0233, 32'h0000_0ABC, 1'b1, 3);  // ADD x4,x0,x3, 3 waits

    // Reset during a fetch wait, with an ack that arrives while reset is high.
    step();
    imem_ack  = 1'b1;
    imem_data = 32'h0000_00B7;
    #2 reset = 1'b1;
    #1;
    check_eq("rstf_req", {63'd0, imem_req}, 64'd0);
    check_eq("rstf_pc", pc, 64'd0);
    check_eq("rstf_instret", instret, 64'd0);
    model_reset();
    step();
    imem_ack = 1'b0;
    #2 reset = 1'b0;
    #1 check_eq("rstf_req_low", {63'd0, imem_req}, 64'd0);
    step();
    check_eq("rstf_req_rise", {63'd0, imem_req}, 64'd1);
    check_eq("rstf_halted", {63'd0, halted}, 64'd0);
    do_insn(32'h0020_81B3, 32'h0000_0063, 1'b1, 0);  // x1,x2 cleared; x3 = 99

    // Reset during EXEC: the pending write to x5 must not happen.
    imem_ack  = 1'b1;
    imem_data = 32'h0000_02B7;                       // LUI x5
    step();
    imem_ack  = 1'b0;
    step();
    rd              = 32'h0000_0055;
    rd_enable_write = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_eq("rste_pc", pc, 64'd0);
    check_eq("rste_opcode", opcode, 64'd0);
    check_eq("rste_imm", imm, 64'd0);
    check_eq("rste_halted", {63'd0, halted}, 64'd0);
    model_reset();
    step();
    #2 reset = 1'b0;
    rd_enable_write = 1'b0;
    step();
    do_insn(32'h0032_8333, 32'h0000_0001, 1'b1, 0);  // ADD x6,x5,x3 -> 0,0

    // Illegal opcode: halts and stays put even with acks offered.
    do_insn(32'h0000_2083, '0, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      imem_ack  = i[0];
      imem_data = 32'h0000_00B7;
      step();
      check_eq("halt_hold_req", {63'd0, imem_req}, 64'd0);
      check_eq("halt_hold_pc", pc, mpc);
      check_eq("halt_hold_flag", {63'd0, halted}, 64'd1);
    end
    imem_ack = 1'b0;
    check_eq("halt_instret", instret, exp_instret());

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
